wb_merge: RTL and testbench

- Writeback merge stage directly upstream of the register file.
- Funnels two result sources into the register file's single write port (load/dest/in):
  - the in-order pipeline writeback (ALU/load results), which cannot stall;
  - the multi-cycle mul/div unit, which uses a valid/ready handshake.
- Mul/div results that lose arbitration wait in a small in-order FIFO.
- Exports a pending-register mask so decode can stall on RAW hazards against buffered results.

---
 rtl/wb_merge_if.sv | 40 ++++
 rtl/wb_merge.sv | 121 ++++++++++++
 tb/tb_wb_merge.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// Writeback merge bus: pipeline writeback, mul/div handshake, register
// file write port, and the hazard/occupancy status exported to decode.
interface wb_merge_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pipe_wb_valid;
  logic [4:0]      pipe_wb_rd;
  logic [XLEN-1:0] pipe_wb_data;

  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;

  logic            rf_load;
  logic [4:0]      rf_dest;
  logic [XLEN-1:0] rf_in;

  logic [31:0]     pending;
  logic [CW-1:0]   count;

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  rf_load, rf_dest, rf_in,
    input  pending, count
  );

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output rf_load, rf_dest, rf_in,
    output pending, count
  );
endinterface

// File: rtl/wb_merge.sv
// Writeback merge: the non-stallable pipeline writeback owns the register
// file port; mul/div results take it when free, else wait in an in-order
// FIFO. A pipeline write to rd kills any older buffered result for rd.
module wb_merge #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic       clk,
  input logic       rst_n,
  wb_merge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [DEPTH-1:0] live_q, live_n;
  logic [4:0]      rd_q [DEPTH];
  logic [4:0]      rd_eff [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [31:0]     pending_q, pending_n;

  logic            md_ready;
  logic            md_acc, pipe_w, empty, head_live, md_keep;
  logic            pop, push, bypass, load;
  logic [4:0]      dest;
  logic [XLEN-1:0] wdata;

  assign md_ready  = count_q < CW'(DEPTH);
  assign md_acc    = bus.md_valid && md_ready;
  assign pipe_w    = bus.pipe_wb_valid && (bus.pipe_wb_rd != 5'd0);
  assign empty     = (count_q == '0);
  assign head_live = !empty && live_q[head_q];
  // A same-cycle pipeline write to the same rd is younger, so the md result is dead.
  assign md_keep   = md_acc && (bus.md_rd != 5'd0) && !(pipe_w && (bus.md_rd == bus.pipe_wb_rd));
  assign push      = md_keep && !bypass;

  // Write-port arbitration: pipe, then live head, then md bypass once the FIFO is (or becomes) empty.
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    load   = 1'b0;
    dest   = 5'd0;
    wdata  = '0;
    if (pipe_w) begin
      load  = 1'b1;
      dest  = bus.pipe_wb_rd;
      wdata = bus.pipe_wb_data;
    end else if (head_live) begin
      load  = 1'b1;
      dest  = rd_q[head_q];
      wdata = data_q[head_q];
      pop   = 1'b1;
    end else begin
      // Killed head drains silently; bypass only if that pop empties the FIFO.
      if (!empty) pop = 1'b1;
      if ((empty || count_q == CW'(1)) && md_keep) begin
        bypass = 1'b1;
        load   = 1'b1;
        dest   = bus.md_rd;
        wdata  = bus.md_data;
      end
    end
  end

  // Next live flags and the pending mask they imply after this edge.
  always_comb begin
    live_n = live_q;
    rd_eff = rd_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_w && (rd_q[i] == bus.pipe_wb_rd)) live_n[i] = 1'b0;
    end
    if (pop) live_n[head_q] = 1'b0;
    if (push) begin
      live_n[tail_q] = 1'b1;
      rd_eff[tail_q] = bus.md_rd;
    end
    pending_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_n[i]) pending_n[rd_eff[i]] = 1'b1;
    end
    pending_n[0] = 1'b0;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      live_q    <= '0;
      pending_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      live_q    <= live_n;
      pending_q <= pending_n;
      if (push) begin
        rd_q[tail_q]   <= bus.md_rd;
        data_q[tail_q] <= bus.md_data;
        tail_q         <= tail_q + AW'(1);
      end
      if (pop) head_q <= head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Write port is held quiet while reset is asserted, regardless of inputs.
  assign bus.rf_load  = rst_n && load;
  assign bus.rf_dest  = rst_n ? dest  : 5'd0;
  assign bus.rf_in    = rst_n ? wdata : '0;
  assign bus.md_ready = md_ready;
  assign bus.pending  = pending_q;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_wb_merge.sv
// Scoreboard bench for wb_merge: expected register-file writes are queued
// in order; a negedge monitor pops and compares every observed write.
module tb_wb_merge;
  logic clk;
  logic rst_n;

  wb_merge_if #(.DEPTH(4), .XLEN(32)) bus ();
  wb_merge #(.DEPTH(4), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t expq[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  k;
  logic acc;

  int exp_cnt [13] = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 3, 2, 1, 0};
  logic [31:0] exp_pend [13] = '{32'h0, 32'h2, 32'h6, 32'hE, 32'h1E, 32'h1E, 32'h1E,
                                 32'h1C, 32'h38, 32'h70, 32'h60, 32'h40, 32'h0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic idle();
    bus.pipe_wb_valid = 1'b0;
    bus.pipe_wb_rd    = 5'd0;
    bus.pipe_wb_data  = 32'h0;
    bus.md_valid      = 1'b0;
    bus.md_rd         = 5'd0;
    bus.md_data       = 32'h0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
    bus.pipe_wb_valid = 1'b1;
    bus.pipe_wb_rd    = rd;
    bus.pipe_wb_data  = data;
  endtask

  task automatic md(input logic [4:0] rd, input logic [31:0] data);
    bus.md_valid = 1'b1;
    bus.md_rd    = rd;
    bus.md_data  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rf_load) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual x%0d=%h required no write", bus.rf_dest, bus.rf_in);
      end else begin
        mon_e = expq.pop_front();
        if (bus.rf_dest !== mon_e.rd || bus.rf_in !== mon_e.data) begin
          errors++;
          $display("FAIL rf_write actual x%0d=%h required x%0d=%h",
                   bus.rf_dest, bus.rf_in, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_count",    32'(bus.count), 32'd0);
    check("reset_pending",  bus.pending,    32'h0);
    check("reset_rf_load",  32'(bus.rf_load), 32'd0);
    check("reset_rf_dest",  32'(bus.rf_dest), 32'd0);
    check("reset_rf_in",    bus.rf_in,      32'h0);
    check("reset_md_ready", 32'(bus.md_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Pipe-only writes, zero latency; x0 is never written.
    pipe(5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    #1 check("pipe_load", 32'(bus.rf_load), 32'd1);
    tick();
    pipe(5'd0, 32'h11111111);
    #1 check("pipe_x0_load", 32'(bus.rf_load), 32'd0);
    tick();

    // Bypass into empty FIFO.
    idle();
    md(5'd7, 32'h12);
    expect_wr(5'd7, 32'h12);
    #1 check("bypass_md_ready", 32'(bus.md_ready), 32'd1);
    check("bypass_load", 32'(bus.rf_load), 32'd1);
    tick();
    idle();
    #1 check("bypass_count", 32'(bus.count), 32'd0);
    check("bypass_pending", bus.pending, 32'h0);

    // md result to x0 is discarded.
    md(5'd0, 32'h99);
    #1 check("md_x0_load", 32'(bus.rf_load), 32'd0);
    tick();
    idle();
    #1 check("md_x0_count", 32'(bus.count), 32'd0);
    tick();

    // Buffer and drain: 6 pipe cycles while md offers x1..x6.
    for (int i = 0; i < 6; i++) expect_wr(5'(20 + i), 32'h100 + i);
    for (int i = 1; i <= 6; i++) expect_wr(5'(i), 32'h1000_0000 + i);
    k = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      idle();
      if (cyc < 6) pipe(5'(20 + cyc), 32'h100 + cyc);
      if (k < 6) md(5'(k + 1), 32'h1000_0000 + k + 1);
      #1;
      check($sformatf("drain_count_c%0d", cyc), 32'(bus.count), 32'(exp_cnt[cyc]));
      check($sformatf("drain_pending_c%0d", cyc), bus.pending, exp_pend[cyc]);
      check($sformatf("drain_md_ready_c%0d", cyc), 32'(bus.md_ready), (exp_cnt[cyc] < 4) ? 32'd1 : 32'd0);
      acc = bus.md_valid && bus.md_ready;
      tick();
      if (acc) k++;
    end
    idle();
    check("drain_all_accepted", 32'(k), 32'd6);

    // Kill: buffer x9=AA behind a pipe write, then pipe overwrites x9.
    pipe(5'd10, 32'h10A);
    md(5'd9, 32'hAA);
    expect_wr(5'd10, 32'h10A);
    #1 check("kill_md_ready", 32'(bus.md_ready), 32'd1);
    tick();
    idle();
    pipe(5'd9, 32'hBB);
    expect_wr(5'd9, 32'hBB);
    #1 check("kill_count_buf", 32'(bus.count), 32'd1);
    check("kill_pending_buf", bus.pending, 32'h200);
    tick();
    // Killed head pops silently and the now-empty FIFO lets md x11 bypass.
    idle();
    md(5'd11, 32'h55);
    expect_wr(5'd11, 32'h55);
    #1 check("kill_pending_cleared", bus.pending, 32'h0);
    check("kill_count_dead", 32'(bus.count), 32'd1);
    check("kill_bypass_dest", 32'(bus.rf_dest), 32'd11);
    tick();
    idle();
    #1 check("kill_count_final", 32'(bus.count), 32'd0);
    check("kill_pending_final", bus.pending, 32'h0);
    tick();

    // Same-cycle collision: pipe x3=1 wins, md x3=2 discarded.
    pipe(5'd3, 32'h1);
    md(5'd3, 32'h2);
    expect_wr(5'd3, 32'h1);
    #1 check("collide_md_ready", 32'(bus.md_ready), 32'd1);
    tick();
    idle();
    #1 check("collide_count", 32'(bus.count), 32'd0);
    check("collide_pending", bus.pending, 32'h0);
    tick();

    // Async reset with three buffered results.
    for (int i = 0; i < 3; i++) begin
      idle();
      pipe(5'(20 + i), 32'h200 + i);
      md(5'(12 + i), 32'h300 + i);
      expect_wr(5'(20 + i), 32'h200 + i);
      tick();
    end
    idle();
    #1 check("prereset_count", 32'(bus.count), 32'd3);
    check("prereset_pending", bus.pending, 32'h7000);
    rst_n = 1'b0;
    #1 check("async_count", 32'(bus.count), 32'd0);
    check("async_pending", bus.pending, 32'h0);
    check("async_rf_load", 32'(bus.rf_load), 32'd0);
    check("async_md_ready", 32'(bus.md_ready), 32'd1);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    check("postreset_count", 32'(bus.count), 32'd0);

    tick();
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
